// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF) and
// load/store (LS), with a req/ack handshake to memory and a timeout abort.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_done,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_ls_req,
    input  logic              i_ls_we,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [DATA_W-1:0] i_ls_wdata,
    input  logic [3:0]        i_ls_bmask,
    output logic              o_ls_done,
    output logic [DATA_W-1:0] o_ls_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_timeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_LS = 2'd2
    } state_t;

    state_t           state;
    logic             last_gnt_ls;
    logic [CNT_W-1:0] wait_cnt;

    logic if_elig;
    logic ls_elig;
    logic pick_ls;
    logic pick_if;

    // A requester whose done is pulsing this cycle is still holding req; skip it.
    always_comb begin
        if_elig = i_if_req && !o_if_done;
        ls_elig = i_ls_req && !o_ls_done;
        pick_ls = ls_elig && (!if_elig || !last_gnt_ls);
        pick_if = if_elig && !pick_ls;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            last_gnt_ls <= 1'b0;
            wait_cnt    <= '0;
            o_if_done   <= 1'b0;
            o_if_rdata  <= '0;
            o_ls_done   <= 1'b0;
            o_ls_rdata  <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_bmask <= '0;
            o_timeout   <= 1'b0;
        end else begin
            o_if_done <= 1'b0;
            o_ls_done <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_ls) begin
                        state       <= ST_BUSY_LS;
                        last_gnt_ls <= 1'b1;
                        wait_cnt    <= '0;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_ls_we;
                        o_mem_addr  <= i_ls_addr;
                        o_mem_wdata <= i_ls_wdata;
                        o_mem_bmask <= i_ls_bmask;
                    end else if (pick_if) begin
                        state       <= ST_BUSY_IF;
                        last_gnt_ls <= 1'b0;
                        wait_cnt    <= '0;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= 1'b0;
                        o_mem_addr  <= i_if_addr;
                        o_mem_wdata <= '0;
                        o_mem_bmask <= 4'hF;
                    end
                end
                ST_BUSY_IF, ST_BUSY_LS: begin
                    // Ack wins over a timeout reached in the same cycle.
                    if (i_mem_ack || (wait_cnt == TO_LAST)) begin
                        state     <= ST_IDLE;
                        o_mem_req <= 1'b0;
                        o_timeout <= !i_mem_ack;
                        if (state == ST_BUSY_IF) begin
                            o_if_done  <= 1'b1;
                            o_if_rdata <= i_mem_ack ? i_mem_rdata : '0;
                        end else begin
                            o_ls_done  <= 1'b1;
                            o_ls_rdata <= (i_mem_ack && !o_mem_we) ? i_mem_rdata : '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
